instr_fetch_issue: RTL and testbench

Instruction fetch and issue stage feeding the main control decoder and ALU control path. Holds the PC, issues one 32-bit request per instruction to instruction memory, latches the returned word, and presents the control inputs to the decoder under a valid/ready handshake: `Opcode` is the 7-bit opcode, and `Funct` is `{instr[30], instr[14:12]}`. It also presents the register fields and the PC. Branch redirects from execute override sequential PC+4.

---
 rtl/instr_fetch_issue_pkg.sv | 40 ++++
 rtl/instr_field_split.sv | 27 ++
 rtl/instr_fetch_issue.sv | 203 ++++++++++++++++++++
 tb/tb_instr_fetch_issue.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_issue_pkg.sv
// Shared definitions for the instruction fetch/issue stage: FSM state
// encoding, instruction word width, major opcode constants and the bit
// positions of the fields that the decoder and ALU control consume.
package instr_fetch_issue_pkg;

    // Fetch/issue FSM states. ST_FAULT is reachable only when the
    // INSTR_FETCH_ALIGN_CHECK_EN build option is defined.
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_ISSUE = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

    localparam int INSTR_WIDTH = 32;

    // Major opcodes recognised by the main control decoder.
    localparam logic [6:0] OPC_R_TYPE = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // Field bit positions inside the 32-bit instruction word.
    localparam int OPCODE_LSB     = 0;
    localparam int OPCODE_MSB     = 6;
    localparam int RD_LSB         = 7;
    localparam int RD_MSB         = 11;
    localparam int FUNCT3_LSB     = 12;
    localparam int FUNCT3_MSB     = 14;
    localparam int RS1_LSB        = 15;
    localparam int RS1_MSB        = 19;
    localparam int RS2_LSB        = 20;
    localparam int RS2_MSB        = 24;
    localparam int FUNCT7_ALT_BIT = 30;

    // True when the two low address bits describe a 4-byte aligned address.
    function automatic logic is_word_aligned(input logic [1:0] low_bits);
        return (low_bits == 2'b00);
    endfunction

endpackage

// File: rtl/instr_field_split.sv
// Combinational extraction of the decoder control inputs and register
// specifiers from a latched instruction word. Funct packs the ALU
// alternate-operation bit (instr[30]) above funct3.
module instr_field_split
    import instr_fetch_issue_pkg::*;
(
    input  logic [INSTR_WIDTH-1:0] i_instr,
    output logic [6:0]             o_opcode,
    output logic [3:0]             o_funct,
    output logic [4:0]             o_rd,
    output logic [4:0]             o_rs1,
    output logic [4:0]             o_rs2
);

    // Bits of funct7 other than the alternate bit are not needed here;
    // the immediate generator reads them from the full word instead.
    logic w_unused_bits;

    assign o_opcode = i_instr[OPCODE_MSB:OPCODE_LSB];
    assign o_funct  = {i_instr[FUNCT7_ALT_BIT], i_instr[FUNCT3_MSB:FUNCT3_LSB]};
    assign o_rd     = i_instr[RD_MSB:RD_LSB];
    assign o_rs1    = i_instr[RS1_MSB:RS1_LSB];
    assign o_rs2    = i_instr[RS2_MSB:RS2_LSB];

    assign w_unused_bits = ^{i_instr[31], i_instr[29:25]};

endmodule

// File: rtl/instr_fetch_issue.sv
// Instruction fetch and issue stage. Holds the PC, requests one word per
// instruction from instruction memory, latches it and presents decoder
// fields under issue_valid/issue_ready. Branch redirects from execute
// override the sequential PC+4.
//
// Handshakes: a transfer happens on a rising clk edge where the producer's
// valid (imem_req / issue_valid) and the consumer's ready (imem_ready /
// issue_ready) are both 1; the producer holds valid and its payload
// (imem_addr / decoded fields) stable until that edge.
//
// Build option INSTR_FETCH_ALIGN_CHECK_EN: when defined, a redirect to a
// target that is not 4-byte aligned parks the stage in FAULT until reset;
// when undefined, target bits [1:0] are ignored and fault is tied to 0.
module instr_fetch_issue
    import instr_fetch_issue_pkg::*;
#(
    parameter int                  PC_WIDTH = 64,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
)(
    input  logic                   clk,
    input  logic                   reset,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_ready,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic                   issue_valid,
    input  logic                   issue_ready,
    output logic [6:0]             Opcode,
    output logic [3:0]             Funct,
    output logic [4:0]             rd,
    output logic [4:0]             rs1,
    output logic [4:0]             rs2,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [PC_WIDTH-1:0]    pc_out,
    input  logic                   branch_taken,
    input  logic [PC_WIDTH-1:0]    branch_target,
    output logic                   fault,
    output logic [1:0]             dbg_state
);

    fetch_state_e           r_state;
    fetch_state_e           w_state_next;

    // r_pc is the architectural PC (target of the next useful fetch);
    // r_imem_addr is the address actually on the bus, which must stay put
    // while a request is outstanding even if r_pc has been redirected.
    logic [PC_WIDTH-1:0]    r_pc;
    logic [PC_WIDTH-1:0]    w_pc_next;
    logic [PC_WIDTH-1:0]    r_imem_addr;
    logic [PC_WIDTH-1:0]    w_addr_next;
    logic [PC_WIDTH-1:0]    r_pc_out;
    logic [INSTR_WIDTH-1:0] r_instr;
    logic                   r_discard;
    logic                   w_discard_next;
    logic                   r_imem_req;
    logic                   r_issue_valid;
    logic                   w_latch;
    logic [PC_WIDTH-1:0]    w_target;
    logic                   w_bad_target;

`ifdef INSTR_FETCH_ALIGN_CHECK_EN
    logic                   r_fault;

    assign w_target     = branch_target;
    assign w_bad_target = branch_taken & ~is_word_aligned(branch_target[1:0]);
`else
    // Misaligned targets are silently rounded down to a word boundary.
    logic                   w_unused_target_lsbs;

    assign w_target             = {branch_target[PC_WIDTH-1:2], 2'b00};
    assign w_bad_target         = 1'b0;
    assign w_unused_target_lsbs = ^branch_target[1:0];
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, next PC, next bus address and discard-flag bookkeeping.
    always_comb begin
        w_state_next   = r_state;
        w_pc_next      = r_pc;
        w_addr_next    = r_imem_addr;
        w_discard_next = r_discard;
        w_latch        = 1'b0;
        case (r_state)
            ST_FETCH: begin
                if (w_bad_target) begin
                    w_state_next = ST_FAULT;
                end else begin
                    if (branch_taken) begin
                        w_pc_next = w_target;
                    end
                    // r_imem_req is low only in the first cycle after reset;
                    // a stray imem_ready there belongs to a killed request.
                    if (r_imem_req && imem_ready) begin
                        if (branch_taken || r_discard) begin
                            // Response is for a stale address: drop it and
                            // refetch from the (possibly new) PC.
                            w_discard_next = 1'b0;
                        end else begin
                            w_latch      = 1'b1;
                            w_state_next = ST_ISSUE;
                        end
                    end else if (r_imem_req && branch_taken) begin
                        // Cannot withdraw the request; remember to drop its
                        // data. Further redirects only move r_pc.
                        w_discard_next = 1'b1;
                    end
                    // Bus address may only change at a request boundary.
                    if (!r_imem_req || imem_ready) begin
                        w_addr_next = w_pc_next;
                    end
                end
            end
            ST_ISSUE: begin
                if (w_bad_target) begin
                    w_state_next = ST_FAULT;
                end else if (branch_taken) begin
                    // Redirect wins over +4 whether or not the current
                    // instruction was accepted in this same cycle.
                    w_pc_next    = w_target;
                    w_state_next = ST_FETCH;
                end else if (issue_ready) begin
                    w_pc_next    = r_pc + PC_WIDTH'(4);
                    w_state_next = ST_FETCH;
                end
                w_addr_next = w_pc_next;
            end
            ST_FAULT: begin
                w_state_next = ST_FAULT;
            end
            default: begin
                w_state_next = ST_FETCH;
            end
        endcase
    end

    // PC, bus address, discard flag and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_imem_addr   <= RESET_PC;
            r_discard     <= 1'b0;
            r_imem_req    <= 1'b0;
            r_issue_valid <= 1'b0;
        end else begin
            r_pc          <= w_pc_next;
            r_imem_addr   <= w_addr_next;
            r_discard     <= w_discard_next;
            r_imem_req    <= (w_state_next == ST_FETCH);
            r_issue_valid <= (w_state_next == ST_ISSUE);
        end
    end

    // Latch the fetched word and its address; held between issues.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr  <= '0;
            r_pc_out <= '0;
        end else if (w_latch) begin
            r_instr  <= imem_rdata;
            r_pc_out <= r_imem_addr;
        end
    end

`ifdef INSTR_FETCH_ALIGN_CHECK_EN
    // Sticky fault indication, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fault <= 1'b0;
        end else begin
            r_fault <= (w_state_next == ST_FAULT);
        end
    end

    assign fault = r_fault;
`else
    assign fault = 1'b0;
`endif

    instr_field_split u_field_split (
        .i_instr  (r_instr),
        .o_opcode (Opcode),
        .o_funct  (Funct),
        .o_rd     (rd),
        .o_rs1    (rs1),
        .o_rs2    (rs2)
    );

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_imem_addr;
    assign issue_valid = r_issue_valid;
    assign instr       = r_instr;
    assign pc_out      = r_pc_out;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_instr_fetch_issue.sv
// Bench for instr_fetch_issue: directed scenarios followed by randomized
// traffic, with a transaction-level model that predicts the PC of every
// presented instruction and the word the memory returns for it.
module tb_instr_fetch_issue;
  import instr_fetch_issue_pkg::*;

  localparam int PW = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          imem_req;
  logic [PW-1:0] imem_addr;
  logic          imem_ready = 1'b0;
  logic [31:0]   imem_rdata;
  logic          issue_valid;
  logic          issue_ready = 1'b0;
  logic [6:0]    Opcode;
  logic [3:0]    Funct;
  logic [4:0]    rd;
  logic [4:0]    rs1;
  logic [4:0]    rs2;
  logic [31:0]   instr;
  logic [PW-1:0] pc_out;
  logic          branch_taken = 1'b0;
  logic [PW-1:0] branch_target = '0;
  logic          fault;
  logic [1:0]    dbg_state;

  instr_fetch_issue #(.PC_WIDTH(PW), .RESET_PC('0)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .Opcode        (Opcode),
    .Funct         (Funct),
    .rd            (rd),
    .rs1           (rs1),
    .rs2           (rs2),
    .instr         (instr),
    .pc_out        (pc_out),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .fault         (fault),
    .dbg_state     (dbg_state)
  );

`ifdef INSTR_FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  // ---------------- memory model ----------------
  // Address-derived word so a stale response shows up as a wrong pc/instr pair.
  function automatic logic [31:0] mem_word(input logic [PW-1:0] a);
    logic [31:0] h;
    logic [6:0]  opc;
    if (a == 64'h200) return 32'h40B50533;
    h = a[31:0] * 32'h9E3779B1 ^ 32'hA5A50F0F;
    case (a[3:2])
      2'd0:    opc = OPC_R_TYPE;
      2'd1:    opc = OPC_LOAD;
      2'd2:    opc = OPC_STORE;
      default: opc = OPC_BRANCH;
    endcase
    return {h[31:7], opc};
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  // exp_q holds the PC of the next instruction that must be presented.
  logic [PW-1:0] exp_q[$];
  bit            model_fault = 1'b0;
  int            issue_cnt = 0;

  bit            prev_reset = 1'b1;
  bit            prev_req, prev_ready, prev_valid, prev_iready, prev_branch;
  logic [PW-1:0] prev_addr, prev_pc_out;
  logic [31:0]   prev_instr;

  always @(negedge clk) begin
    logic [31:0] w;
    if (prev_reset) begin
      check("rst_req", imem_req, 1'b0);
      check("rst_valid", issue_valid, 1'b0);
      check("rst_fault", fault, 1'b0);
    end else begin
      check("fault_state", fault, model_fault);
      if (model_fault) begin
        check("fault_req", imem_req, 1'b0);
        check("fault_valid", issue_valid, 1'b0);
      end
      if (prev_req && !prev_ready && !model_fault) begin
        check("req_held", imem_req, 1'b1);
        check("addr_held", imem_addr, prev_addr);
      end
      if (prev_valid && !prev_iready && !prev_branch) begin
        check("valid_held", issue_valid, 1'b1);
        check("instr_held", instr, prev_instr);
        check("pc_held", pc_out, prev_pc_out);
      end
      if (issue_valid && !prev_valid) begin
        issue_cnt++;
        if (exp_q.size() == 0) begin
          check("issue_unexpected", 1'b1, 1'b0);
        end else begin
          check("issue_pc", pc_out, exp_q.pop_front());
          w = mem_word(pc_out);
          check("issue_instr", instr, w);
          check("issue_opcode", Opcode, w[6:0]);
          check("issue_funct", Funct, {w[30], w[14:12]});
          check("issue_regs", {rd, rs1, rs2}, {w[11:7], w[19:15], w[24:20]});
        end
      end
    end
    // model update for the coming edge
    if (reset) begin
      exp_q.delete();
      exp_q.push_back('0);
      model_fault = 1'b0;
    end else if (!model_fault) begin
      if (branch_taken) begin
        if (ALIGN_CHECK && branch_target[1:0] != 2'b00) begin
          model_fault = 1'b1;
        end else begin
          exp_q.delete();
          exp_q.push_back({branch_target[PW-1:2], 2'b00});
        end
      end else if (issue_valid && issue_ready) begin
        exp_q.delete();
        exp_q.push_back(pc_out + 64'd4);
      end
    end
    prev_reset  = reset;
    prev_req    = imem_req;
    prev_ready  = imem_ready;
    prev_addr   = imem_addr;
    prev_valid  = issue_valid;
    prev_iready = issue_ready;
    prev_branch = branch_taken;
    prev_instr  = instr;
    prev_pc_out = pc_out;
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit rdy, input bit irdy, input bit br, input logic [PW-1:0] tgt);
    imem_ready    = rdy;
    issue_ready   = irdy;
    branch_taken  = br;
    branch_target = tgt;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int base_cnt;
    logic [PW-1:0] tgt;
    drive(1'b0, 1'b0, 1'b0, '0);
    reset = 1'b1;
    repeat (3) cyc();
    check("reset_req", imem_req, 1'b0);
    check("reset_valid", issue_valid, 1'b0);
    check("reset_addr", imem_addr, 64'h0);
    check("reset_instr", instr, 32'h0);
    check("reset_pc_out", pc_out, 64'h0);
    check("reset_fields", {Opcode, Funct, rd, rs1, rs2}, 26'h0);
    check("reset_fault", fault, 1'b0);

    // sequential stream with imem_ready tied high
    reset = 1'b0;
    drive(1'b1, 1'b1, 1'b0, '0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("seq_req", imem_req, 1'b1);
      check("seq_addr", imem_addr, 64'(4 * k));
      check("seq_valid_low", issue_valid, 1'b0);
      cyc();
      check("seq_valid", issue_valid, 1'b1);
      check("seq_req_low", imem_req, 1'b0);
      check("seq_pc", pc_out, 64'(4 * k));
    end

    // handshake + redirect to the sub x10,x10,x11 word
    drive(1'b1, 1'b1, 1'b1, 64'h200);
    cyc();
    check("redir_addr", imem_addr, 64'h200);
    drive(1'b1, 1'b0, 1'b0, '0);
    cyc();
    check("sub_valid", issue_valid, 1'b1);
    check("sub_instr", instr, 32'h40B50533);
    check("sub_opcode", Opcode, OPC_R_TYPE);
    check("sub_funct", Funct, 4'b1000);
    check("sub_rd", rd, 5'd10);
    check("sub_rs1", rs1, 5'd10);
    check("sub_rs2", rs2, 5'd11);

    // downstream stall for 5 cycles
    for (int k = 0; k < 5; k++) begin
      cyc();
      check("stall_valid", issue_valid, 1'b1);
      check("stall_req", imem_req, 1'b0);
      check("stall_pc", pc_out, 64'h200);
      check("stall_instr", instr, 32'h40B50533);
    end
    drive(1'b0, 1'b1, 1'b0, '0);
    cyc();
    check("after_stall_addr", imem_addr, 64'h204);

    // redirect to 0x100 while the response stalls 3 cycles
    drive(1'b0, 1'b0, 1'b1, 64'h100);
    cyc();
    check("pend_addr_held", imem_addr, 64'h204);
    drive(1'b0, 1'b0, 1'b0, '0);
    cyc();
    cyc();
    check("pend_req_held", imem_req, 1'b1);
    drive(1'b1, 1'b0, 1'b0, '0);
    cyc();
    check("discard_no_issue", issue_valid, 1'b0);
    check("discard_new_addr", imem_addr, 64'h100);
    check("discard_req", imem_req, 1'b1);
    cyc();
    check("target_issue_pc", pc_out, 64'h100);

    // redirect beats +4 in the accept cycle
    drive(1'b1, 1'b1, 1'b1, 64'h40);
    cyc();
    check("redir_beats_inc", imem_addr, 64'h40);
    drive(1'b1, 1'b0, 1'b0, '0);
    cyc();
    check("redir40_pc", pc_out, 64'h40);

    // misaligned redirect
    drive(1'b1, 1'b0, 1'b1, 64'h102);
    cyc();
    if (ALIGN_CHECK) begin
      drive(1'b1, 1'b1, 1'b0, '0);
      for (int k = 0; k < 4; k++) begin
        check("mis_fault", fault, 1'b1);
        check("mis_req", imem_req, 1'b0);
        check("mis_valid", issue_valid, 1'b0);
        cyc();
      end
      reset = 1'b1;
      cyc();
      check("mis_reset_clear", fault, 1'b0);
      reset = 1'b0;
      cyc();
    end else begin
      check("mis_fault0", fault, 1'b0);
      check("mis_round_addr", imem_addr, 64'h100);
      drive(1'b1, 1'b0, 1'b0, '0);
      cyc();
      check("mis_round_pc", pc_out, 64'h100);
    end

    // reset while a fetch is outstanding
    drive(1'b0, 1'b1, 1'b0, '0);
    cyc();
    cyc();
    check("mid_req", imem_req, 1'b1);
    reset = 1'b1;
    imem_ready = 1'b1;
    cyc();
    check("mid_rst_req", imem_req, 1'b0);
    check("mid_rst_valid", issue_valid, 1'b0);
    reset = 1'b0;
    cyc();
    check("post_rst_req", imem_req, 1'b1);
    check("post_rst_addr", imem_addr, 64'h0);
    cyc();
    check("post_rst_pc", pc_out, 64'h0);

    // randomized traffic
    base_cnt = issue_cnt;
    for (int k = 0; k < 3000; k++) begin
      tgt = 64'($urandom_range(0, 1023)) << 2;
      if ($urandom_range(0, 7) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 15) == 0, tgt);
      reset = (fault == 1'b1) || ($urandom_range(0, 499) == 0);
      cyc();
    end
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0);
    cyc();
    check("random_progress", (issue_cnt - base_cnt) >= 100, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
